hough_peak_reader: RTL

- Reader for the Hough accumulator RAM that FSMHough fills. Starts when a frame's accumulation is complete.
- Scans every (rho address, theta) cell once and emits each cell whose vote count is at or above THRESHOLD as a peak (one detected line).
- Tracks the global maximum cell and reports it when the scan ends.
- Sits between the accumulator RAM read port and the downstream line-drawing/overlay logic.

---
 rtl/hough_peak_reader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hough_peak_reader.sv
// rtl/hough_peak_reader.sv - Hough accumulator scanner: emits cells at/above THRESHOLD as peaks, reports the global maximum
// Optional: define HOUGH_CLEAR_AFTER_READ_EN to add wr_en and zero each cell as it is checked.
module hough_peak_reader #(
    parameter int RHO_W       = 11,
    parameter int THETA_W     = 8,
    parameter int VOTE_W      = 11,
    parameter int RHO_COUNT   = 2048,
    parameter int THETA_COUNT = 180,
    parameter int THRESHOLD   = 100
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               rd_en,
    output logic [RHO_W-1:0]   rd_address,
    output logic [THETA_W-1:0] rd_theta,
    input  logic [VOTE_W-1:0]  rd_data,
    output logic               peak_valid,
    input  logic               peak_ready,
    output logic [RHO_W-1:0]   peak_rho,
    output logic [THETA_W-1:0] peak_theta,
    output logic [VOTE_W-1:0]  peak_votes,
    output logic               busy,
    output logic               done,
    output logic [RHO_W-1:0]   max_rho,
    output logic [THETA_W-1:0] max_theta,
    output logic [VOTE_W-1:0]  max_votes
`ifdef HOUGH_CLEAR_AFTER_READ_EN
    ,
    output logic               wr_en
`endif
);

    localparam logic [RHO_W-1:0]   RHO_LAST   = RHO_W'(RHO_COUNT - 1);
    localparam logic [THETA_W-1:0] THETA_LAST = THETA_W'(THETA_COUNT - 1);
    localparam logic [VOTE_W-1:0]  THR        = VOTE_W'(THRESHOLD);

    typedef enum logic [2:0] {IDLE, ISSUE, CHECK, EMIT, FINISH} state_t;

    state_t             state, state_nxt;
    logic [RHO_W-1:0]   rho_cnt;
    logic [THETA_W-1:0] theta_cnt;
    logic               clear_scan;
    logic               advance;
    logic               hit;
    logic               new_max;
    logic               last_rho;
    logic               last_cell;

    assign last_rho  = (rho_cnt == RHO_LAST);
    assign last_cell = last_rho && (theta_cnt == THETA_LAST);
    assign hit       = (rd_data >= THR);
    // First cell always seeds the maximum; afterwards only a strictly larger count replaces it.
    assign new_max   = ((rho_cnt == '0) && (theta_cnt == '0)) || (rd_data > max_votes);

`ifdef HOUGH_CLEAR_AFTER_READ_EN
    // Address stays on the checked cell through CHECK so the RAM can zero it.
    assign wr_en      = (state == CHECK);
    assign rd_address = rho_cnt;
    assign rd_theta   = theta_cnt;
`else
    assign rd_address = rd_en ? rho_cnt : '0;
    assign rd_theta   = rd_en ? theta_cnt : '0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        clear_scan = 1'b0;
        advance    = 1'b0;
        rd_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear_scan = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                rd_en     = 1'b1;
                busy      = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (hit) begin
                    state_nxt = EMIT;
                end else begin
                    advance   = 1'b1;
                    state_nxt = last_cell ? FINISH : ISSUE;
                end
            end
            EMIT: begin
                busy = 1'b1;
                if (peak_ready) begin
                    advance   = 1'b1;
                    state_nxt = last_cell ? FINISH : ISSUE;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Rho is the fast index; both counters return to zero after the final cell.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rho_cnt   <= '0;
            theta_cnt <= '0;
        end else if (clear_scan) begin
            rho_cnt   <= '0;
            theta_cnt <= '0;
        end else if (advance) begin
            if (last_cell) begin
                rho_cnt   <= '0;
                theta_cnt <= '0;
            end else if (last_rho) begin
                rho_cnt   <= '0;
                theta_cnt <= theta_cnt + THETA_W'(1);
            end else begin
                rho_cnt <= rho_cnt + RHO_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            max_rho   <= '0;
            max_theta <= '0;
            max_votes <= '0;
        end else if (clear_scan) begin
            max_rho   <= '0;
            max_theta <= '0;
            max_votes <= '0;
        end else if ((state == CHECK) && new_max) begin
            max_rho   <= rho_cnt;
            max_theta <= theta_cnt;
            max_votes <= rd_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            peak_valid <= 1'b0;
            peak_rho   <= '0;
            peak_theta <= '0;
            peak_votes <= '0;
        end else if ((state == CHECK) && hit) begin
            peak_valid <= 1'b1;
            peak_rho   <= rho_cnt;
            peak_theta <= theta_cnt;
            peak_votes <= rd_data;
        end else if ((state == EMIT) && peak_ready) begin
            peak_valid <= 1'b0;
        end
    end

endmodule
